// File: rtl/time_set_controller.sv
// Run/set sequencer for the hh:mm:ss counter chain: 1 s tick prescaler, button-driven field editing, load strobe.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on inc/dec while editing.
module time_set_controller #(
  parameter int TICK_DIV   = 50000000,
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic [5:0] hh_in,
  input  logic [5:0] mm_in,
  input  logic [5:0] ss_in,
  output logic       tick,
  output logic       load,
  output logic [5:0] hh_set,
  output logic [5:0] mm_set,
  output logic [5:0] ss_set,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(TICK_DIV / 2);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(TICK_DIV / 2 - 1);

  if (TICK_DIV < 4 || (TICK_DIV % 2) != 0 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_check
    $error("time_set_controller: illegal parameter set");
  end

  state_t        r_state;
  logic          r_tick;
  logic          r_load;
  logic          r_blink;
  logic [5:0]    r_hh;
  logic [5:0]    r_mm;
  logic [5:0]    r_ss;
  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_blink_cnt;
  logic          r_mode_hist;
  logic          r_inc_hist;
  logic          r_dec_hist;

  logic w_mode_press;
  logic w_inc_press;
  logic w_dec_press;
  logic w_step;
  logic w_step_up;

  assign w_mode_press = mode_btn & ~r_mode_hist;
  assign w_inc_press  = inc_btn & ~r_inc_hist;
  assign w_dec_press  = dec_btn & ~r_dec_hist;

`ifdef AUTO_REPEAT_EN
  logic [31:0] r_rpt_cnt;
  logic        r_rpt_armed;
  logic        w_rpt_hold;
  logic        w_rpt_fire;
  logic [31:0] w_rpt_target;

  // Only a steady single-button hold counts; a fresh press starts the count from zero.
  assign w_rpt_hold   = (r_state != RUN) && !w_mode_press && (inc_btn ^ dec_btn)
                        && !w_inc_press && !w_dec_press;
  assign w_rpt_target = r_rpt_armed ? 32'(REPEAT_PER) : 32'(REPEAT_DLY);
  assign w_rpt_fire   = w_rpt_hold && ((r_rpt_cnt + 32'd1) == w_rpt_target);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rpt_cnt   <= 32'd0;
      r_rpt_armed <= 1'b0;
    end else if (!w_rpt_hold) begin
      r_rpt_cnt   <= 32'd0;
      r_rpt_armed <= 1'b0;
    end else if (w_rpt_fire) begin
      r_rpt_cnt   <= 32'd0;
      r_rpt_armed <= 1'b1;
    end else begin
      r_rpt_cnt   <= r_rpt_cnt + 32'd1;
    end
  end

  assign w_step    = (w_inc_press ^ w_dec_press) | w_rpt_fire;
  assign w_step_up = w_inc_press | (w_rpt_fire & inc_btn);
`else
  assign w_step    = w_inc_press ^ w_dec_press;
  assign w_step_up = w_inc_press;
`endif

  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] maxv,
                                            input logic up);
    if (v > maxv)  return 6'd0;
    else if (up)   return (v == maxv) ? 6'd0 : v + 6'd1;
    else           return (v == 6'd0) ? maxv : v - 6'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_tick      <= 1'b0;
      r_load      <= 1'b0;
      r_blink     <= 1'b0;
      r_hh        <= 6'd0;
      r_mm        <= 6'd0;
      r_ss        <= 6'd0;
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_mode_hist <= 1'b0;
      r_inc_hist  <= 1'b0;
      r_dec_hist  <= 1'b0;
    end else begin
      r_mode_hist <= mode_btn;
      r_inc_hist  <= inc_btn;
      r_dec_hist  <= dec_btn;
      r_tick      <= 1'b0;
      r_load      <= 1'b0;

      if (r_state == RUN) begin
        r_blink <= 1'b0;
        if (w_mode_press) begin
          r_state     <= SET_HH;
          r_hh        <= hh_in;
          r_mm        <= mm_in;
          r_ss        <= ss_in;
          r_presc     <= '0;
          r_blink     <= 1'b1;
          r_blink_cnt <= '0;
        end else if (r_presc == PRESC_LAST) begin
          r_presc <= '0;
          r_tick  <= 1'b1;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end else if (w_mode_press) begin
        // Mode has priority over edits on the same edge.
        r_blink     <= 1'b1;
        r_blink_cnt <= '0;
        case (r_state)
          SET_HH:  r_state <= SET_MM;
          SET_MM:  r_state <= SET_SS;
          default: begin
            r_state <= RUN;
            r_load  <= 1'b1;
            r_blink <= 1'b0;
            r_presc <= '0;
          end
        endcase
      end else if (w_step) begin
        case (r_state)
          SET_HH:  r_hh <= step_field(r_hh, 6'd23, w_step_up);
          SET_MM:  r_mm <= step_field(r_mm, 6'd59, w_step_up);
          default: r_ss <= step_field(r_ss, 6'd59, w_step_up);
        endcase
        r_blink     <= 1'b1;
        r_blink_cnt <= '0;
      end else if (r_blink_cnt == BLINK_LAST) begin
        r_blink     <= ~r_blink;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  assign tick   = r_tick;
  assign load   = r_load;
  assign hh_set = r_hh;
  assign mm_set = r_mm;
  assign ss_set = r_ss;
  assign mode   = r_state;
  assign blink  = r_blink;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed test-plan scenarios plus a randomized run
// against a cycle-count based reference model.
module tb_time_set_controller;
  localparam int TD = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       dec_btn = 1'b0;
  logic [5:0] hh_in = 6'd0;
  logic [5:0] mm_in = 6'd0;
  logic [5:0] ss_in = 6'd0;
  logic       tick;
  logic       load;
  logic       blink;
  logic [5:0] hh_set;
  logic [5:0] mm_set;
  logic [5:0] ss_set;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  // Reference model state: mode, shadows, cycles since RUN began, cycles since SET entry/edit.
  logic [1:0] m_mode;
  logic [5:0] m_hh, m_mm, m_ss;
  bit         m_tick, m_load, m_blink;
  bit         p_mode, p_inc, p_dec;
  int         run_age, set_age;

  time_set_controller #(.TICK_DIV(TD), .REPEAT_DLY(30), .REPEAT_PER(7)) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .hh_in(hh_in), .mm_in(mm_in), .ss_in(ss_in), .tick(tick), .load(load),
    .hh_set(hh_set), .mm_set(mm_set), .ss_set(ss_set), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (got no finish, need finish)");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] edit_val(input logic [5:0] v, input int modulus, input bit up);
    int x;
    x = int'(v);
    if (x >= modulus) return 6'd0;
    return 6'((x + (up ? 1 : modulus - 1)) % modulus);
  endfunction

  task automatic model_reset();
    m_mode = 2'd0; m_hh = 6'd0; m_mm = 6'd0; m_ss = 6'd0;
    m_tick = 0; m_load = 0; m_blink = 0;
    p_mode = 0; p_inc = 0; p_dec = 0;
    run_age = 0; set_age = 0;
  endtask

  task automatic model_update();
    bit mp, ip, dp;
    mp = mode_btn && !p_mode;
    ip = inc_btn && !p_inc;
    dp = dec_btn && !p_dec;
    p_mode = mode_btn; p_inc = inc_btn; p_dec = dec_btn;
    m_tick = 0; m_load = 0;
    if (m_mode == 2'd0) begin
      if (mp) begin
        m_mode = 2'd1; m_hh = hh_in; m_mm = mm_in; m_ss = ss_in; set_age = 0;
      end else begin
        run_age++;
        m_tick = (run_age % TD) == 0;
      end
    end else if (mp) begin
      if (m_mode == 2'd3) begin
        m_mode = 2'd0; m_load = 1; run_age = 0;
      end else begin
        m_mode = m_mode + 2'd1; set_age = 0;
      end
    end else if (ip != dp) begin
      case (m_mode)
        2'd1:    m_hh = edit_val(m_hh, 24, ip);
        2'd2:    m_mm = edit_val(m_mm, 60, ip);
        default: m_ss = edit_val(m_ss, 60, ip);
      endcase
      set_age = 0;
    end else begin
      set_age++;
    end
    m_blink = (m_mode != 2'd0) && (((set_age / (TD / 2)) % 2) == 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else model_update();
    #1;
  endtask

  task automatic press(input bit m, input bit i, input bit d);
    mode_btn = m; inc_btn = i; dec_btn = d;
    cycle();
    mode_btn = 0; inc_btn = 0; dec_btn = 0;
    cycle();
  endtask

  task automatic test_reset();
    reset = 0;
    model_reset();
    repeat (3) cycle();
    checks++;
    if ({mode, tick, load, blink} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: mode/tick/load/blink=%b need 00000", {mode, tick, load, blink});
    end
    checks++;
    if ({hh_set, mm_set, ss_set} !== 18'd0) begin
      errors++;
      $display("FAIL reset_fields: got %0d/%0d/%0d need 0/0/0", hh_set, mm_set, ss_set);
    end
    reset = 1;
    $display("test_reset done");
  endtask

  task automatic test_run_tick();
    int first, count;
    first = -1; count = 0;
    for (int c = 1; c <= 35; c++) begin
      cycle();
      checks++;
      if (tick !== m_tick) begin
        errors++;
        $display("FAIL run_tick cycle %0d: got %b need %b", c, tick, m_tick);
      end
      checks++;
      if ({mode, load, blink} !== 4'b0) begin
        errors++;
        $display("FAIL run_state cycle %0d: mode/load/blink=%b need 0000", c, {mode, load, blink});
      end
      if (tick === 1'b1) begin
        if (first < 0) first = c;
        count++;
      end
    end
    checks++;
    if (first != 10 || count != 3) begin
      errors++;
      $display("FAIL run_tick_timing: first=%0d count=%0d need first=10 count=3", first, count);
    end
    $display("test_run_tick done: first tick at %0d, %0d ticks", first, count);
  endtask

  task automatic test_set_hh();
    hh_in = 6'd23; mm_in = 6'd59; ss_in = 6'd58;
    press(1, 0, 0);
    checks++;
    if (mode !== 2'd1 || {hh_set, mm_set, ss_set} !== {6'd23, 6'd59, 6'd58} || blink !== 1'b1) begin
      errors++;
      $display("FAIL set_entry: mode=%0d fields=%0d/%0d/%0d blink=%b need 1 23/59/58 1",
               mode, hh_set, mm_set, ss_set, blink);
    end
    for (int c = 0; c < 12; c++) begin
      cycle();
      checks++;
      if (tick !== 1'b0 || blink !== m_blink) begin
        errors++;
        $display("FAIL set_hold cycle %0d: tick=%b blink=%b need 0 %b", c, tick, blink, m_blink);
      end
    end
    press(0, 1, 0);
    checks++;
    if (hh_set !== 6'd0) begin
      errors++;
      $display("FAIL hh_inc_wrap: got %0d need 0", hh_set);
    end
    press(0, 0, 1);
    checks++;
    if (hh_set !== 6'd23) begin
      errors++;
      $display("FAIL hh_dec_wrap: got %0d need 23", hh_set);
    end
    $display("test_set_hh done: hh_set=%0d", hh_set);
  endtask

  task automatic test_set_mm();
    press(1, 0, 0);
    checks++;
    if (mode !== 2'd2 || mm_set !== 6'd59) begin
      errors++;
      $display("FAIL mm_entry: mode=%0d mm=%0d need 2 59", mode, mm_set);
    end
    press(0, 1, 0);
    checks++;
    if (mm_set !== 6'd0) begin
      errors++;
      $display("FAIL mm_inc_wrap: got %0d need 0", mm_set);
    end
    press(0, 0, 1);
    checks++;
    if (mm_set !== 6'd59) begin
      errors++;
      $display("FAIL mm_dec_wrap: got %0d need 59", mm_set);
    end
    inc_btn = 1;
    repeat (20) cycle();
    inc_btn = 0;
    cycle();
    checks++;
    if (mm_set !== 6'd0) begin
      errors++;
      $display("FAIL mm_hold_single: got %0d need 0", mm_set);
    end
    press(0, 0, 1);
    $display("test_set_mm done: mm_set=%0d", mm_set);
  endtask

  task automatic test_simultaneous();
    press(0, 1, 1);
    checks++;
    if (mm_set !== 6'd59 || mode !== 2'd2) begin
      errors++;
      $display("FAIL inc_dec_same: mm=%0d mode=%0d need 59 2", mm_set, mode);
    end
    press(1, 1, 0);
    checks++;
    if (mode !== 2'd3 || ss_set !== 6'd58 || mm_set !== 6'd59) begin
      errors++;
      $display("FAIL mode_wins: mode=%0d ss=%0d mm=%0d need 3 58 59", mode, ss_set, mm_set);
    end
    $display("test_simultaneous done: mode=%0d", mode);
  endtask

  task automatic test_load();
    int k;
    mode_btn = 1;
    cycle();
    mode_btn = 0;
    checks++;
    if (load !== 1'b1 || tick !== 1'b0 || mode !== 2'd0 ||
        {hh_set, mm_set, ss_set} !== {6'd23, 6'd59, 6'd58}) begin
      errors++;
      $display("FAIL load_strobe: load=%b tick=%b mode=%0d fields=%0d/%0d/%0d need 1 0 0 23/59/58",
               load, tick, mode, hh_set, mm_set, ss_set);
    end
    k = 0;
    do begin
      cycle();
      k++;
      checks++;
      if (load !== 1'b0 || blink !== 1'b0) begin
        errors++;
        $display("FAIL load_one_cycle: load=%b blink=%b need 0 0 (cycle %0d)", load, blink, k);
      end
    end while (tick !== 1'b1 && k < 20);
    checks++;
    if (k != 10) begin
      errors++;
      $display("FAIL tick_after_load: got %0d cycles need 10", k);
    end
    $display("test_load done: tick %0d cycles after load", k);
  endtask

  task automatic test_reset_mid_set();
    int k;
    hh_in = 6'd5; mm_in = 6'd6; ss_in = 6'd7;
    press(1, 0, 0);
    press(1, 0, 0);
    checks++;
    if (mode !== 2'd2) begin
      errors++;
      $display("FAIL mid_set_entry: mode=%0d need 2", mode);
    end
    reset = 0;
    model_reset();
    #1;
    checks++;
    if (mode !== 2'd0 || {hh_set, mm_set, ss_set} !== 18'd0 || load !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: mode=%0d fields=%0d/%0d/%0d load=%b need 0 0/0/0 0",
               mode, hh_set, mm_set, ss_set, load);
    end
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (load !== 1'b0 || tick !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_load: load=%b tick=%b need 0 0", load, tick);
      end
    end
    reset = 1;
    k = 0;
    do begin
      cycle();
      k++;
      checks++;
      if (load !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_load_after: load=%b need 0", load);
      end
    end while (tick !== 1'b1 && k < 20);
    checks++;
    if (k != 10) begin
      errors++;
      $display("FAIL tick_after_abort: got %0d cycles need 10", k);
    end
    $display("test_reset_mid_set done: tick %0d cycles after release", k);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 11) == 0) mode_btn = ~mode_btn;
      if ($urandom_range(0, 3) == 0)  inc_btn  = ~inc_btn;
      if ($urandom_range(0, 3) == 0)  dec_btn  = ~dec_btn;
      hh_in = 6'($urandom_range(0, 63));
      mm_in = 6'($urandom_range(0, 63));
      ss_in = 6'($urandom_range(0, 63));
      cycle();
      checks++;
      if (mode !== m_mode || tick !== m_tick || load !== m_load || blink !== m_blink) begin
        errors++;
        $display("FAIL rand_ctrl cycle %0d: mode/tick/load/blink=%0d/%b/%b/%b need %0d/%b/%b/%b",
                 c, mode, tick, load, blink, m_mode, m_tick, m_load, m_blink);
      end
      checks++;
      if ({hh_set, mm_set, ss_set} !== {m_hh, m_mm, m_ss}) begin
        errors++;
        $display("FAIL rand_fields cycle %0d: got %0d/%0d/%0d need %0d/%0d/%0d",
                 c, hh_set, mm_set, ss_set, m_hh, m_mm, m_ss);
      end
      checks++;
      if (tick === 1'b1 && load === 1'b1) begin
        errors++;
        $display("FAIL tick_load_overlap cycle %0d: both 1 need exclusive", c);
      end
    end
    mode_btn = 0; inc_btn = 0; dec_btn = 0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_set_hh();
    test_set_mm();
    test_simultaneous();
    test_load();
    test_reset_mid_set();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
